// File: rtl/mem_d_pkg.sv
// Shared FSM state type and default geometry for the D-matrix bank writer.
package mem_d_pkg;

    localparam int N1_DEF     = 4;
    localparam int N2_DEF     = 4;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_d_addr_gen.sv
// Column / bank-row / phase counters and bank address for the D fill.
// N2 must be a power of two so the in-group reversal reduces to an XOR.
module mem_d_addr_gen
    import mem_d_pkg::*;
#(
    parameter int N1           = N1_DEF,
    parameter int N2           = N2_DEF,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int ROW_W        = (N1 > 1) ? $clog2(N1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    step_i,
    input  logic [MATRIXSIZE_W-1:0] m3_i,
    input  logic [MATRIXSIZE_W-1:0] m1dn1_i,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [ROW_W-1:0]        row_o,
    output logic                    last_o
);

    localparam logic [MATRIXSIZE_W-1:0] ONE      = MATRIXSIZE_W'(1);
    localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(N1 - 1);
    localparam logic [ADDR_W-1:0]       GRP_MASK = ADDR_W'(N2 - 1);

    logic [MATRIXSIZE_W-1:0] col_q, col_d;
    logic [MATRIXSIZE_W-1:0] phase_q, phase_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ADDR_W-1:0]       offset_q, offset_d;
    logic                    col_end, row_end, phase_end;

    assign col_end   = (col_q == m3_i - ONE);
    assign row_end   = (row_q == ROW_LAST);
    assign phase_end = (phase_q == m1dn1_i - ONE);
    assign last_o    = col_end && row_end && phase_end;
    assign row_o     = row_q;

    // Only the low ADDR_W bits of phase*M3 + col' are ever used, so the
    // offset is kept at ADDR_W; modular addition gives the same truncation.
    assign addr_o = offset_q + (col_q[ADDR_W-1:0] ^ GRP_MASK);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        offset_d = offset_q;
        if (clear_i) begin
            col_d    = '0;
            row_d    = '0;
            phase_d  = '0;
            offset_d = '0;
        end else if (step_i) begin
            if (!col_end) begin
                col_d = col_q + ONE;
            end else begin
                col_d = '0;
                if (!row_end) begin
                    row_d = row_q + ROW_W'(1);
                end else begin
                    row_d = '0;
                    if (phase_end) begin
                        phase_d  = '0;
                        offset_d = '0;
                    end else begin
                        phase_d  = phase_q + ONE;
                        offset_d = offset_q + m3_i[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            phase_q  <= '0;
            offset_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            phase_q  <= phase_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/mem_write_d.sv
// Streams the D matrix into N1 banks with N2-group reversed addressing.
// Optional MEM_WRITE_D_COUNT_EN adds a saturating wr_count of write pulses.
module mem_write_d
    import mem_d_pkg::*;
#(
    parameter int N1           = N1_DEF,
    parameter int N2           = N2_DEF,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M3,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [N1-1:0]           wr_en,
    output logic                    busy,
    output logic                    done
`ifdef MEM_WRITE_D_COUNT_EN
    ,
    output logic [31:0]             wr_count
`endif
);

    localparam int            ROW_W  = (N1 > 1) ? $clog2(N1) : 1;
    localparam logic [N1-1:0] EN_ONE = N1'(1);

    state_t                  state_q;
    logic                    busy_q, done_q;
    logic [MATRIXSIZE_W-1:0] m3_q, m1dn1_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [DATA_W-1:0]       wr_data_q;
    logic [N1-1:0]           wr_en_q;

    logic                    xfer, start_acc, dims_zero, last;
    logic [ADDR_W-1:0]       gen_addr;
    logic [ROW_W-1:0]        gen_row;

    // busy_q tracks state==WRITE exactly, so it doubles as in_ready.
    assign xfer      = in_valid && busy_q;
    assign start_acc = start && (state_q != WRITE);
    assign dims_zero = (M3 == '0) || (M1dN1 == '0);

    mem_d_addr_gen #(
        .N1           (N1),
        .N2           (N2),
        .MATRIXSIZE_W (MATRIXSIZE_W),
        .ADDR_W       (ADDR_W),
        .ROW_W        (ROW_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_acc),
        .step_i   (xfer),
        .m3_i     (m3_q),
        .m1dn1_i  (m1dn1_q),
        .addr_o   (gen_addr),
        .row_o    (gen_row),
        .last_o   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m3_q      <= '0;
            m1dn1_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
        end else begin
            wr_en_q <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        m3_q    <= M3;
                        m1dn1_q <= M1dN1;
                        if (dims_zero) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (in_valid) begin
                        wr_en_q   <= EN_ONE << gen_row;
                        wr_addr_q <= gen_addr;
                        wr_data_q <= in_data;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;

`ifdef MEM_WRITE_D_COUNT_EN
    logic [31:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            wr_count_q <= '0;
        end else if ((|wr_en_q) && (wr_count_q != '1)) begin
            wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_write_d.sv
// Randomised and directed bench for mem_write_d against a queue-based write model.
// Define MEM_WRITE_D_COUNT_EN to also check wr_count.
module tb_mem_write_d;

    localparam int N1     = 4;
    localparam int N2     = 4;
    localparam int ADDR_W = 12;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [15:0] M3, M1dN1, in_data;
    logic        in_ready, busy, done;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_en;
`ifdef MEM_WRITE_D_COUNT_EN
    logic [31:0] wr_count;
`endif

    mem_write_d dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .M3       (M3),
        .M1dN1    (M1dN1),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done)
`ifdef MEM_WRITE_D_COUNT_EN
        ,
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int addr;
    } wr_t;

    wr_t         exp_q[$];
    int          m_state = 0;   // 0 idle, 1 writing, 2 done
    logic [3:0]  exp_en = '0;
    logic [11:0] exp_addr = '0;
    logic [15:0] exp_data = '0;
    logic [31:0] exp_cnt = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wn = 0;
    int          spot_n[$];
    int          spot_b[$];
    int          spot_a[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected write order straight from the placement rule.
    task automatic build(input int m3, input int m1);
        wr_t e;
        exp_q.delete();
        for (int p = 0; p < m1; p++)
            for (int r = 0; r < N1; r++)
                for (int c = 0; c < m3; c++) begin
                    e.bank = r;
                    e.addr = (p * m3 + (c / N2) * N2 + (N2 - 1 - (c % N2))) % (1 << ADDR_W);
                    exp_q.push_back(e);
                end
    endtask

    task automatic cycle();
        logic [3:0] prev_en;
        bit         acc;
        bit         chk_all;
        wr_t        e;
        prev_en = exp_en;
        chk_all = 0;
        if (rst) begin
            exp_q.delete();
            m_state  = 0;
            exp_en   = '0;
            exp_addr = '0;
            exp_data = '0;
            exp_cnt  = '0;
            chk_all  = 1;
        end else begin
            acc    = start && (m_state != 1);
            exp_en = '0;
            if (in_valid && m_state == 1) begin
                e        = exp_q.pop_front();
                exp_en   = 4'(1 << e.bank);
                exp_addr = 12'(e.addr);
                exp_data = in_data;
                if (exp_q.size() == 0) m_state = 2;
            end
            if (acc) begin
                build(int'(M3), int'(M1dN1));
                m_state = (exp_q.size() == 0) ? 2 : 1;
                exp_cnt = '0;
            end else if (prev_en != 0 && exp_cnt != 32'hFFFF_FFFF) begin
                exp_cnt = exp_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        chk_eq("wr_en", 32'(wr_en), 32'(exp_en));
        if (exp_en != 0 || chk_all) begin
            chk_eq("wr_addr", 32'(wr_addr), 32'(exp_addr));
            chk_eq("wr_data", 32'(wr_data), 32'(exp_data));
        end
        chk_eq("in_ready", 32'(in_ready), 32'(m_state == 1));
        chk_eq("busy", 32'(busy), 32'(m_state == 1));
        chk_eq("done", 32'(done), 32'(m_state == 2));
`ifdef MEM_WRITE_D_COUNT_EN
        chk_eq("wr_count", wr_count, exp_cnt);
`endif
        if (exp_en != 0) begin
            wn++;
            foreach (spot_n[i])
                if (spot_n[i] == wn) begin
                    chk_eq("spot_bank", 32'(wr_en), 32'(1) << spot_b[i]);
                    chk_eq("spot_addr", 32'(wr_addr), 32'(spot_a[i]));
                end
        end
    endtask

    task automatic step(input bit s, input bit v);
        start    = s;
        in_valid = v;
        in_data  = 16'($urandom);
        cycle();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic set_spots(input int n, input int b, input int a);
        spot_n.push_back(n);
        spot_b.push_back(b);
        spot_a.push_back(a);
    endtask

    task automatic clear_spots();
        spot_n.delete();
        spot_b.delete();
        spot_a.delete();
        wn = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        M3 = '0; M1dN1 = '0;
        do_reset();

        // Full 8x2 fill with landmark addresses
        M3 = 16'd8; M1dN1 = 16'd2;
        clear_spots();
        set_spots(1, 0, 3); set_spots(5, 0, 7); set_spots(9, 1, 3);
        set_spots(33, 0, 11); set_spots(64, 3, 12);
        step(1, 1);
        for (int i = 0; i < 64; i++) step(0, 1);
        chk_eq("fill_done", 32'(done), 32'd1);
        chk_eq("fill_writes", 32'(wn), 32'd64);
`ifdef MEM_WRITE_D_COUNT_EN
        step(0, 0);
        chk_eq("fill_count", wr_count, 32'd64);
`endif
        step(0, 0);

        // Stall after the 10th element
        clear_spots();
        set_spots(11, 1, 1);
        step(1, 0);
`ifdef MEM_WRITE_D_COUNT_EN
        chk_eq("count_clr", wr_count, 32'd0);
`endif
        for (int i = 0; i < 10; i++) step(0, 1);
        for (int i = 0; i < 3; i++) step(0, 0);
        for (int i = 0; i < 60 && m_state == 1; i++) step(0, 1);
        chk_eq("stall_done", 32'(done), 32'd1);
        chk_eq("stall_writes", 32'(wn), 32'd64);

        // Zero dimensions
        M3 = 16'd0; M1dN1 = 16'd2;
        step(1, 1);
        chk_eq("zero_m3_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 1);
        M3 = 16'd8; M1dN1 = 16'd0;
        step(1, 1);
        chk_eq("zero_m1_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1);

        // Reset mid-fill, then restart from IDLE
        M3 = 16'd8; M1dN1 = 16'd2;
        step(1, 0);
        for (int i = 0; i < 20; i++) step(0, 1);
        do_reset();
        step(0, 1);
        clear_spots();
        set_spots(1, 0, 3);
        step(1, 0);
        for (int i = 0; i < 80 && m_state == 1; i++) step(0, 1);

        // Restart in DONE with 4x1; start pulses while writing are ignored
        clear_spots();
        set_spots(16, 3, 0);
        M3 = 16'd4; M1dN1 = 16'd1;
        step(1, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin M3 = 16'd8; M1dN1 = 16'd3; end
            step(i == 5 || i == 11, 1);
        end
        chk_eq("restart_done", 32'(done), 32'd1);
        chk_eq("restart_writes", 32'(wn), 32'd16);
        step(0, 0);

        // Randomised fills with stalls, ignored starts and input churn
        clear_spots();
        for (int t = 0; t < 14; t++) begin
            M3    = 16'(N2 * $urandom_range(0, 3));
            M1dN1 = 16'($urandom_range(0, 3));
            step(1, $urandom_range(0, 1) == 1);
            for (int i = 0; i < 400 && m_state == 1; i++) begin
                M3    = 16'($urandom);
                M1dN1 = 16'($urandom);
                if ($urandom_range(0, 99) == 0) begin
                    do_reset();
                    break;
                end
                step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            end
            step(0, 0);
            step(0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_write_d.md
MEM_WRITE_D -- requirements
Module: mem_write_d

Interface
REQ-001 Parameters (name, default, meaning): N1, 4, systolic rows and D banks; N2, 4, mini-column group width; MATRIXSIZE_W, 16, matrix-dimension width; ADDR_W, 12, bank address width; DATA_W, 16, element width.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse that begins a fill; sampled only in IDLE or DONE.
REQ-005 M3  in  MATRIXSIZE_W  D columns; latched at accepted start.
REQ-006 M1dN1  in  MATRIXSIZE_W  row phases (M1/N1); latched at accepted start.
REQ-007 in_data  in  DATA_W  D element, order phase-outer, then bank row, then column.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 wr_addr  out  ADDR_W  bank write address.
REQ-011 wr_data  out  DATA_W  bank write data.
REQ-012 wr_en  out  N1  one-hot bank write enable; bit k selects bank k.
REQ-013 busy  out  1  high in WRITE.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 FSM states are IDLE, WRITE and DONE; the reset state is IDLE.
REQ-016 IDLE→WRITE on start when M3≠0 and M1dN1≠0; IDLE→DONE on start when either is 0; start in WRITE is ignored.
REQ-017 in_ready shall equal (state==WRITE); a transfer occurs when in_valid && in_ready.
REQ-018 Counters col (0..M3-1), sys_row (0..N1-1) and phase (0..M1dN1-1) advance only on a transfer: col wraps to sys_row+1, and sys_row wraps to phase+1.
REQ-019 Address per transfer = phase*M3 + (col/N2)*N2 + (N2-1-(col mod N2)), so each N2 group is stored reversed; a running offset is used (add M3 per phase), with no multiplier.
REQ-020 wr_en = one-hot(sys_row), with wr_addr and wr_data registered one cycle after the transfer; wr_en = 0 in every cycle without a transfer.
REQ-021 The transfer with phase=M1dN1-1, sys_row=N1-1 and col=M3-1 is the last transfer: the FSM goes WRITE→DONE and in_ready drops the next cycle.
REQ-022 DONE holds until start; start in DONE re-latches M3 and M1dN1, clears counters and re-enters WRITE, or DONE again if a dimension is 0.
REQ-023 M3 shall be a multiple of N2; other values are not supported.
REQ-024 Address arithmetic is computed at MATRIXSIZE_W and truncated to ADDR_W; overflow is not detected.
REQ-025 in_valid low stalls the counters and generates no write; there are no bubbles.

Reset
REQ-026 rst forces IDLE and sets every counter, the offset, wr_addr, wr_data and wr_en to 0, with in_ready, busy and done at 0, from the next edge.
REQ-027 rst mid-fill discards all progress; no wr_en pulse follows reset.

Configuration
REQ-028 With MEM_WRITE_D_COUNT_EN defined, output wr_count[31:0] counts wr_en pulses; it clears on rst and on an accepted start and saturates at all-ones.
REQ-029 Without MEM_WRITE_D_COUNT_EN, the wr_count port and its logic are absent.

Structure
REQ-030 Package mem_d_pkg holds the FSM state enum (IDLE/WRITE/DONE) and the shared default constants N1/N2/ADDR_W; mem_read_D is not changed.
REQ-031 One sub-module, mem_d_addr_gen, holds the col/sys_row/phase/offset counters and the address formula; the top holds the FSM, the handshake and the output registers.

Verification (N1=4, N2=4, M3=8, M1dN1=2, in_valid constant 1)
REQ-032 Fill: start then 64 elements → 1st write bank0 addr 3, 5th (col4) bank0 addr 7, 9th (row1 col0) bank1 addr 3, 33rd (phase1) bank0 addr 11, 64th bank3 addr 12; done high the cycle after the 64th transfer.
REQ-033 Stall: in_valid low for 3 cycles after the 10th element → no wr_en for 3 cycles, then the 11th write is bank1 addr 1, with addresses continuous.
REQ-034 Zero dimension: start with M3=0 → DONE the next cycle, in_ready never high, wr_en never high.
REQ-035 Reset mid-fill: rst after 20 transfers → all outputs 0; a new start then makes its first write bank0 addr 3.
REQ-036 Restart: start in DONE with M3=4, M1dN1=1 → 16 writes with last bank3 addr 0, then done; start pulsed in WRITE is ignored.
REQ-037 With MEM_WRITE_D_COUNT_EN: after the REQ-032 fill wr_count=64; it clears to 0 on the next start.
